// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson/ring sequencer with decoded index, wrap pulse and illegal-state flag.
// Optional build macro: SELF_CORRECT_EN (forces illegal patterns back to the mode's reset value).
module johnson_counter_gen #(
  parameter  int N  = 4,
  localparam int IW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  counter,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          err
);

  typedef enum logic {
    JOHNSON = 1'b0,
    RING    = 1'b1
  } mode_e;

  localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW:0]   TWO_N  = (IW+1)'(2*N);
  localparam logic [IW-1:0] LAST_J = IW'(2*N-1);
  localparam logic [IW-1:0] LAST_R = IW'(N-1);

  mode_e         mode_q;
  logic [N-1:0]  t;
  logic [N-1:0]  nxt;
  logic [IW:0]   pop;
  logic [IW:0]   j_idx;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] last;
  logic          j_legal;
  logic          r_legal;
  logic          legal;
  logic          adv_wrap;

  function automatic logic [N-1:0] rst_val(input logic m);
    return {{(N-1){1'b0}}, m};
  endfunction

  always_comb begin
    pop   = '0;
    r_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + (IW+1)'(counter[i]);
      if (counter[i]) r_idx = IW'(i);
    end

    // A Johnson pattern is a run of ones anchored at bit 0, or its complement.
    t       = counter[N-1] ? ~counter : counter;
    j_legal = ((t & (t + ONE)) == '0);
    r_legal = (counter != '0) && ((counter & (counter - ONE)) == '0);
    legal   = (mode_q == RING) ? r_legal : j_legal;
    err     = !legal;

    j_idx = counter[N-1] ? (TWO_N - pop) : pop;
    if (err)                 idx = '0;
    else if (mode_q == RING) idx = r_idx;
    else                     idx = j_idx[IW-1:0];

    last     = (mode_q == RING) ? LAST_R : LAST_J;
    adv_wrap = legal && (dir ? (idx == '0) : (idx == last));

    nxt = counter;
    case ({mode_q == RING, dir})
      2'b00:   nxt = {counter[N-2:0], ~counter[N-1]};
      2'b01:   nxt = {~counter[0], counter[N-1:1]};
      2'b10:   nxt = {counter[N-2:0], counter[N-1]};
      default: nxt = {counter[0], counter[N-1:1]};
    endcase
  end

  // Reset value tracks the live mode input, so the async reset value is data-dependent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= mode_e'(mode);
      counter <= rst_val(mode);
      wrap    <= 1'b0;
    end else if (mode_e'(mode) != mode_q) begin
      mode_q  <= mode_e'(mode);
      counter <= rst_val(mode);
      wrap    <= 1'b0;
    end else if (load) begin
      counter <= load_val;
      wrap    <= 1'b0;
`ifdef SELF_CORRECT_EN
    end else if (err) begin
      counter <= rst_val(mode_q);
      wrap    <= 1'b0;
`endif
    end else if (en) begin
      counter <= nxt;
      wrap    <= adv_wrap;
    end else begin
      wrap    <= 1'b0;
    end
  end

endmodule
